gol_sequencer: RTL and testbench
================================

# gol_sequencer

Phase sequencer for the Game-of-Life simulation engine. Owns the phase state machine (IDLE/UPDATE/COPY/INIT) that the board update, copy and randomize engines run under, and gates each generation to a frame boundary. Supports a rate timer, pause, single-step and per-phase timeout supervision. Sits between the pad-level controls (run, step, randomize), the VGA sync generator and the three board-memory engines, which it drives through start/done pulse handshakes.

## Interface
Parameters:
- UPDATE_INTERVAL, 2400000: minimum clock cycles between generations while running (10 Hz at 24 MHz).
- TIMEOUT, 65535: maximum cycles any phase may take before its done pulse arrives.
- GEN_W, 16: width of the generation counter.

Ports:
- clk  in  1  system clock (pixel clock)
- rst_n  in  1  reset; one clock, reset is synchronous and active-low
- run  in  1  level; 1 = free-running generations, 0 = paused
- step  in  1  level; rising edge while paused requests exactly one generation
- randomize  in  1  level; sampled at trigger: 1 = run INIT instead of UPDATE
- vsync  in  1  vertical sync from hvsync generator; rising edge is the frame boundary
- update_start / copy_start / init_start  out  1 each  one-cycle start pulses to engines
- update_done / copy_done / init_done  in  1 each  one-cycle completion pulses from engines
- phase  out  2  0 IDLE, 1 UPDATE, 2 COPY, 3 INIT
- busy  out  1  1 whenever phase != IDLE
- generation  out  GEN_W  completed generations since last INIT
- timeout_err  out  1  sticky phase-timeout flag

## Operation
- States: IDLE, UPDATE, COPY, INIT. Reset state INIT (boot randomize).
- Reset values: phase=3, busy=1, all *_start=0, generation=0, timeout_err=0, timer=0, step_pending=0, vsync/step edge registers=0.
- First cycle after rst_n deasserts: init_start=1 (boot INIT is always run).
- Entry to UPDATE/COPY/INIT: matching *_start=1 for exactly the entry cycle; phase cycle counter cleared.
- UPDATE --update_done--> COPY. COPY --copy_done--> IDLE, generation+1 (wraps modulo 2^GEN_W). INIT --init_done--> IDLE, generation=0.
- Done pulses not matching the current phase, or arriving in IDLE, are ignored. Done in the start-pulse cycle is accepted.
- IDLE timer: increments each cycle while run=1, saturates at UPDATE_INTERVAL, holds while run=0, cleared on trigger.
- Step: step rising edge in IDLE with run=0 sets step_pending; edges while busy or run=1 are dropped.
- Trigger (IDLE only): vsync rising edge AND (run=1 and timer==UPDATE_INTERVAL, OR step_pending=1). Next state INIT if randomize=1 else UPDATE; step_pending cleared.
- Timeout: phase counter reaching TIMEOUT without matching done -> timeout_err=1, go to IDLE next cycle, generation unchanged. A done in the same cycle wins over the timeout.
- run dropping mid-phase does not abort the phase; the generation completes.
- rst_n low mid-phase: immediate return to reset values next edge; engines must also be reset by rst_n.

## Timing
- vsync edge detect uses one register: edge at cycle T when vsync=1 and vsync_q=0.
- Trigger at T -> phase updates and *_start=1 at T+1.
- Done at cycle D -> next phase and next *_start at D+1; COPY done at C -> phase=0, generation incremented, visible at C+1; timer resumes counting at C+1.
- Timeout: counter=TIMEOUT at cycle X -> timeout_err=1 and phase=0 at X+1.
- All outputs registered; no combinational input-to-output paths.

## Test plan
- Boot: release rst_n -> init_start=1 in first cycle, phase=3; init_done at cycle 20 -> phase=0, busy=0 at 21, generation=0.
- Free run (UPDATE_INTERVAL=100): run=1, vsync rise at cycle 150 -> update_start at 151; update_done at 300 -> copy_start at 301; copy_done at 400 -> phase=0, generation=1 at 401.
- Interval gating: vsync rise at timer=50 -> no start; next rise after timer saturates -> update_start one cycle later.
- Pause/step: run=0, two step edges while idle, vsync rises -> exactly one generation (generation 1->2), then no further starts across three frames.
- Randomize: randomize=1 at trigger -> init_start (not update_start); init_done -> generation=0.
- Timeout (TIMEOUT=50): withhold update_done -> timeout_err=1 and phase=0 at 51 cycles after update_start; stray copy_done in IDLE ignored; timeout_err holds until rst_n low.

Source files
------------

// File: rtl/gol_sequencer.sv
// gol_sequencer: IDLE/UPDATE/COPY/INIT phase machine that paces Game-of-Life generations to vsync.
// Latency: trigger or done sampled at cycle T -> new phase and its start pulse at T+1; all outputs registered.
// Backpressure: none; engines answer start with a done pulse, a phase running TIMEOUT cycles is abandoned and flagged.
module gol_sequencer #(
    parameter int UPDATE_INTERVAL = 2400000,
    parameter int TIMEOUT         = 65535,
    parameter int GEN_W           = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             step,
    input  logic             randomize,
    input  logic             vsync,
    output logic             update_start,
    output logic             copy_start,
    output logic             init_start,
    input  logic             update_done,
    input  logic             copy_done,
    input  logic             init_done,
    output logic [1:0]       phase,
    output logic             busy,
    output logic [GEN_W-1:0] generation,
    output logic             timeout_err
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_UPDATE = 2'd1;
    localparam logic [1:0] S_COPY   = 2'd2;
    localparam logic [1:0] S_INIT   = 2'd3;

    localparam int TMR_W = $clog2(UPDATE_INTERVAL + 1);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(UPDATE_INTERVAL);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    logic             vsync_q;
    logic             step_q;
    logic             step_pending;
    logic             boot_q;
    logic [TMR_W-1:0] timer;
    logic [CNT_W-1:0] phase_cnt;

    logic             vsync_edge;
    logic             step_edge;
    logic             done_match;
    logic             trigger;

    logic [1:0]       phase_nxt;
    logic [GEN_W-1:0] gen_nxt;
    logic             err_nxt;
    logic [TMR_W-1:0] timer_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             pend_nxt;
    logic             upd_start_nxt;
    logic             copy_start_nxt;
    logic             init_start_nxt;

    // Edge detects, done qualification and the frame-aligned generation trigger.
    always_comb begin
        vsync_edge = vsync & ~vsync_q;
        step_edge  = step & ~step_q;
        done_match = ((phase == S_UPDATE) && update_done) ||
                     ((phase == S_COPY)   && copy_done)   ||
                     ((phase == S_INIT)   && init_done);
        trigger    = (phase == S_IDLE) && vsync_edge &&
                     ((run && (timer == TMR_MAX)) || step_pending);
    end

    // Next-state logic; the boot cycle only fires init_start and restarts the phase counter.
    always_comb begin
        phase_nxt      = phase;
        gen_nxt        = generation;
        err_nxt        = timeout_err;
        timer_nxt      = timer;
        cnt_nxt        = phase_cnt;
        pend_nxt       = step_pending;
        upd_start_nxt  = 1'b0;
        copy_start_nxt = 1'b0;
        init_start_nxt = 1'b0;

        if (boot_q) begin
            init_start_nxt = 1'b1;
            cnt_nxt        = '0;
        end else if (phase == S_IDLE) begin
            if (run && (timer != TMR_MAX)) begin
                timer_nxt = timer + TMR_W'(1);
            end
            if (step_edge && !run) begin
                pend_nxt = 1'b1;
            end
            // Trigger clears a pending step even if another edge lands in the same cycle.
            if (trigger) begin
                timer_nxt = '0;
                pend_nxt  = 1'b0;
                cnt_nxt   = '0;
                if (randomize) begin
                    phase_nxt      = S_INIT;
                    init_start_nxt = 1'b1;
                end else begin
                    phase_nxt     = S_UPDATE;
                    upd_start_nxt = 1'b1;
                end
            end
        end else begin
            cnt_nxt = phase_cnt + CNT_W'(1);
            // A done arriving on the timeout cycle takes priority over the timeout.
            if (done_match) begin
                case (phase)
                    S_UPDATE: begin
                        phase_nxt      = S_COPY;
                        copy_start_nxt = 1'b1;
                        cnt_nxt        = '0;
                    end
                    S_COPY: begin
                        phase_nxt = S_IDLE;
                        gen_nxt   = generation + GEN_W'(1);
                    end
                    default: begin
                        phase_nxt = S_IDLE;
                        gen_nxt   = '0;
                    end
                endcase
            end else if (phase_cnt == CNT_MAX) begin
                phase_nxt = S_IDLE;
                err_nxt   = 1'b1;
            end
        end
    end

    // State registers; synchronous reset parks the machine in INIT for the boot randomize.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase        <= S_INIT;
            busy         <= 1'b1;
            update_start <= 1'b0;
            copy_start   <= 1'b0;
            init_start   <= 1'b0;
            generation   <= '0;
            timeout_err  <= 1'b0;
            timer        <= '0;
            phase_cnt    <= '0;
            step_pending <= 1'b0;
            vsync_q      <= 1'b0;
            step_q       <= 1'b0;
            boot_q       <= 1'b1;
        end else begin
            phase        <= phase_nxt;
            busy         <= (phase_nxt != S_IDLE);
            update_start <= upd_start_nxt;
            copy_start   <= copy_start_nxt;
            init_start   <= init_start_nxt;
            generation   <= gen_nxt;
            timeout_err  <= err_nxt;
            timer        <= timer_nxt;
            phase_cnt    <= cnt_nxt;
            step_pending <= pend_nxt;
            vsync_q      <= vsync;
            step_q       <= step;
            boot_q       <= 1'b0;
        end
    end

endmodule

// File: tb/tb_gol_sequencer.sv
// tb_gol_sequencer: directed-plus-random bench for gol_sequencer against a small behavioural model.
// Latency: inputs driven and outputs sampled on the falling edge, one rising edge per tick.
// Backpressure: not applicable; every wait is a fixed number of ticks.
module tb_gol_sequencer;

    localparam int UI = 100;
    localparam int TO = 50;
    localparam int GW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          run;
    logic          step;
    logic          rnd_sel;
    logic          vsync;
    logic          update_start;
    logic          copy_start;
    logic          init_start;
    logic          update_done;
    logic          copy_done;
    logic          init_done;
    logic [1:0]    phase;
    logic          busy;
    logic [GW-1:0] generation;
    logic          timeout_err;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model: phase, generation count, sticky error, run-cycles spent idle, pending step.
    int m_phase;
    int m_gen;
    int m_err;
    int m_timer;
    int m_step;

    always #5 clk = ~clk;

    gol_sequencer #(
        .UPDATE_INTERVAL(UI),
        .TIMEOUT        (TO),
        .GEN_W          (GW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
        .step        (step),
        .randomize   (rnd_sel),
        .vsync       (vsync),
        .update_start(update_start),
        .copy_start  (copy_start),
        .init_start  (init_start),
        .update_done (update_done),
        .copy_done   (copy_done),
        .init_done   (init_done),
        .phase       (phase),
        .busy        (busy),
        .generation  (generation),
        .timeout_err (timeout_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, ".phase"}, 32'(phase), 32'(m_phase));
        check({tag, ".busy"}, 32'(busy), (m_phase != 0) ? 32'd1 : 32'd0);
        check({tag, ".gen"}, 32'(generation), 32'(m_gen));
        check({tag, ".err"}, 32'(timeout_err), 32'(m_err));
    endtask

    task automatic check_starts(input string tag, input int u, input int c, input int i);
        check({tag, ".update_start"}, 32'(update_start), 32'(u));
        check({tag, ".copy_start"}, 32'(copy_start), 32'(c));
        check({tag, ".init_start"}, 32'(init_start), 32'(i));
    endtask

    // One rising edge; the idle timer only advances while idle with run high.
    task automatic tick();
        if (m_phase == 0 && run) m_timer++;
        @(negedge clk);
    endtask

    task automatic idle_wait(input int n);
        for (int k = 0; k < n; k++) begin
            tick();
            check_starts("wait", 0, 0, 0);
            check("wait.phase", 32'(phase), 32'(m_phase));
        end
    endtask

    task automatic model_reset();
        m_phase = 3;
        m_gen   = 0;
        m_err   = 0;
        m_timer = 0;
        m_step  = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        run   = 1'b0;
        step  = 1'b0;
        vsync = 1'b0;
        model_reset();
        repeat (3) tick();
        check_state("reset");
        check_starts("reset", 0, 0, 0);
        rst_n = 1'b1;
        tick();
        check_starts("boot", 0, 0, 1);
        check_state("boot");
    endtask

    task automatic vsync_rise(input string tag);
        int trig;
        int rz;
        trig = (m_phase == 0) && ((run && m_timer >= UI) || m_step != 0);
        rz   = rnd_sel;
        vsync = 1'b1;
        tick();
        if (trig) begin
            m_phase = rz ? 3 : 1;
            m_timer = 0;
            m_step  = 0;
            check_starts(tag, rz ? 0 : 1, 0, rz ? 1 : 0);
        end else begin
            check_starts(tag, 0, 0, 0);
        end
        check_state(tag);
        vsync = 1'b0;
        tick();
        check_starts({tag, ".after"}, 0, 0, 0);
    endtask

    task automatic step_pulse();
        int takes;
        takes = (m_phase == 0) && !run;
        step = 1'b1;
        tick();
        step = 1'b0;
        tick();
        if (takes) m_step = 1;
        check_starts("step", 0, 0, 0);
    endtask

    // kind: 1 update_done, 2 copy_done, 3 init_done
    task automatic pulse_done(input string tag, input int kind);
        int cs;
        cs = 0;
        update_done = (kind == 1);
        copy_done   = (kind == 2);
        init_done   = (kind == 3);
        tick();
        update_done = 1'b0;
        copy_done   = 1'b0;
        init_done   = 1'b0;
        if (m_phase == kind) begin
            if (kind == 1) begin
                m_phase = 2;
                cs = 1;
            end else if (kind == 2) begin
                m_phase = 0;
                m_gen = (m_gen + 1) % (1 << GW);
            end else begin
                m_phase = 0;
                m_gen = 0;
            end
        end
        check_starts(tag, 0, cs, 0);
        check_state(tag);
    endtask

    initial begin
        rst_n = 1'b0; run = 1'b0; step = 1'b0; rnd_sel = 1'b0; vsync = 1'b0;
        update_done = 1'b0; copy_done = 1'b0; init_done = 1'b0;
        model_reset();

        // Boot randomize: stray done ignored, init_done returns to idle with generation 0.
        do_reset();
        idle_wait($urandom_range(5, 25));
        pulse_done("boot_stray", 1);
        pulse_done("boot_done", 3);

        // Interval gating: early and one-short vsync edges do nothing, the saturated one triggers.
        run = 1'b1;
        idle_wait(50);
        vsync_rise("gate_50");
        idle_wait(99 - m_timer);
        vsync_rise("gate_99");
        vsync_rise("gate_sat");
        // run dropping and a step while busy neither abort nor queue anything.
        run = 1'b0;
        step_pulse();
        pulse_done("upd_stray_copy", 2);
        pulse_done("upd_stray_init", 3);
        idle_wait($urandom_range(1, 15));
        pulse_done("upd_done", 1);
        idle_wait($urandom_range(1, 15));
        pulse_done("copy_done", 2);
        vsync_rise("paused_no_trig");

        // Free run with random frame spacing; copy_done lands in the copy_start cycle.
        run = 1'b1;
        for (int it = 0; it < 4; it++) begin
            idle_wait($urandom_range(0, 150));
            vsync_rise("free");
            if (m_phase == 1) begin
                idle_wait($urandom_range(0, 10));
                pulse_done("free_upd", 1);
                pulse_done("free_copy", 2);
            end
        end

        // Step while running is dropped.
        step_pulse();
        run = 1'b0;
        vsync_rise("run_step_dropped");

        // Pause/step: two edges give exactly one generation, then nothing for three frames.
        idle_wait(3);
        step_pulse();
        step_pulse();
        vsync_rise("step_trig");
        pulse_done("step_upd", 1);
        idle_wait(4);
        pulse_done("step_copy", 2);
        for (int f = 0; f < 3; f++) begin
            idle_wait($urandom_range(5, 20));
            vsync_rise("step_quiet");
        end

        // Done on the timeout cycle wins.
        step_pulse();
        vsync_rise("edge_trig");
        idle_wait(TO - 1);
        pulse_done("edge_done", 1);
        pulse_done("edge_copy", 2);

        // Timeout: withheld update_done -> idle with sticky error 51 cycles after update_start.
        step_pulse();
        vsync_rise("to_trig");
        idle_wait(TO - 1);
        tick();
        m_phase = 0;
        m_err   = 1;
        check_starts("timeout", 0, 0, 0);
        check_state("timeout");
        pulse_done("idle_stray_copy", 2);
        idle_wait(5);
        check_state("err_hold");

        // Randomize at trigger runs INIT and clears the generation count.
        step_pulse();
        rnd_sel = 1'b1;
        vsync_rise("rand_trig");
        rnd_sel = 1'b0;
        idle_wait($urandom_range(1, 20));
        pulse_done("rand_done", 3);

        // Reset mid-phase returns to reset values and reboots.
        step_pulse();
        vsync_rise("rst_trig");
        idle_wait(3);
        do_reset();
        pulse_done("reboot_done", 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
